single_port_ram_arbiter: RTL and testbench
==========================================

// Module: single_port_ram_arbiter
// PURPOSE
//  Shares one single_port_ram instance (1-cycle registered read, byte write enables)
//  between two requesters: port A (CPU data side) and port B (DMA / debug loader).
//  Issues at most one RAM access per cycle and returns read data one cycle after the grant.
//  Arbitration is round-robin with a bounded burst length, so neither port starves.
// PARAMETERS
//  ADDR_WIDTH  12  RAM word address width
//  DATA_WIDTH  16  RAM data width; must be a multiple of 8 (NB = DATA_WIDTH/8 byte lanes)
//  MAX_BURST   4   maximum consecutive grants to one port while the other port is requesting (1..15)
// PORTS
//  clk         in   1           clock, rising edge
//  reset       in   1           synchronous, active-high reset
//  a_req       in   1           A requests an access; held with its command until a_ack
//  a_addr      in   ADDR_WIDTH  A word address
//  a_din       in   DATA_WIDTH  A write data
//  a_we        in   NB          A byte write enables; all zero = read
//  a_ack       out  1           A command issued to the RAM this cycle
//  a_rd_valid  out  1           a_dout holds read data for the A read acked last cycle
//  a_dout      out  DATA_WIDTH  A read data
//  b_*         -    -           identical set for port B (b_req, b_addr, b_din, b_we, b_ack, b_rd_valid, b_dout)
//  ram_addr    out  ADDR_WIDTH  to single_port_ram addr
//  ram_din     out  DATA_WIDTH  to single_port_ram din
//  ram_we      out  NB          to single_port_ram write_en
//  ram_dout    in   DATA_WIDTH  from single_port_ram dout
// BEHAVIOUR
//  - Reset (synchronous): a_ack=b_ack=0, a_rd_valid=b_rd_valid=0, ram_we=0, ram_addr=0, ram_din=0,
//    a_dout=b_dout=0, priority pointer=A, burst counter=0, owner=NONE.
//    While reset=1, a_ack, b_ack and ram_we are forced to 0 regardless of requests.
//  - Grant is combinational within the cycle. Winner rules:
//    only one port requesting -> that port wins;
//    neither port requesting -> no grant, ram_we=0, ram_addr/ram_din hold their last values;
//    both requesting -> the priority-pointer port wins, unless it has reached MAX_BURST
//    consecutive grants, in which case the other port wins.
//  - Winner command is driven onto ram_addr/ram_din/ram_we; x_ack=1 in the same cycle.
//    The loser sees x_ack=0 and keeps its command stable.
//  - Burst counter and pointer (registered):
//    grant to the same port as the previous grant -> counter+1, saturating at MAX_BURST;
//    grant to the other port -> counter=1 and pointer = granted port;
//    idle cycle -> counter=0; pointer unchanged.
//  - Uncontested grants increment the counter but never block; the MAX_BURST limit applies
//    only while both ports request.
//  - Read return: a read acked on cycle T (x_we==0) gives x_rd_valid=1 on T+1 only,
//    with x_dout=ram_dout.
//    x_dout is updated only on rd_valid cycles and holds its value otherwise.
//    A write produces no rd_valid.
//  - Back-to-back: one access per cycle, sustained. rd_valid for access N coincides with
//    the ack of access N+1.
//  - Reset mid-operation: a read acked on the cycle before reset asserts produces no rd_valid.
//    State returns to reset values.
//  - A deasserted x_req that was never acked is dropped silently, with no side effects.
//    Requests with no ack never write the RAM.
// TESTING
//  1. A alone, writes 0x1234 to addr 5 (a_we=2'b11), then reads addr 5
//     -> a_ack on both cycles; a_rd_valid=1 with a_dout=0x1234 one cycle after the read ack.
//  2. Both ports request continuously with MAX_BURST=4, pointer at A
//     -> grant sequence A,A,A,A,B,B,B,B,A...; no cycle lacks a grant.
//  3. Byte lanes: write 0xAAAA to addr 9, then B writes 0x55xx with b_we=2'b10, then reads addr 9
//     -> b_dout=0x55AA.
//  4. A writes addr 3 in the same cycle B reads addr 3, pointer at B
//     -> B is acked first and returns the old data; A is acked next cycle.
//     A subsequent read of addr 3 returns A's data.
//  5. Assert reset in the cycle after an A read ack
//     -> a_rd_valid stays 0; all outputs take reset values.
//     After reset release, the first contested grant goes to A.
//  6. Only B requests for 10 cycles, then A joins
//     -> B is never blocked; A is acked on the second contested cycle at the latest.

Source files
------------

// File: rtl/single_port_ram_arbiter.sv
// ============================================================================
// Module      : single_port_ram_arbiter
// Description : Round-robin, burst-bounded arbiter sharing one single-port RAM
//               between two requesters, with one-cycle read data return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module single_port_ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  output logic                    a_ack,
  output logic                    a_rd_valid,
  output logic [DATA_WIDTH-1:0]   a_dout,
  input  logic                    b_req,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_din,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  output logic                    b_ack,
  output logic                    b_rd_valid,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int          c_nb        = DATA_WIDTH / 8;
  localparam logic [3:0]  c_max_burst = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t                r_owner;
  logic                  r_ptr_b;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [DATA_WIDTH-1:0] r_last_din;
  logic                  r_rd_a;
  logic                  r_rd_b;
  logic [DATA_WIDTH-1:0] r_dout_a;
  logic [DATA_WIDTH-1:0] r_dout_b;

  logic   w_gnt_a;
  logic   w_gnt_b;
  logic   w_limit;
  owner_t w_ptr_owner;
  owner_t w_new_owner;

  assign w_ptr_owner = r_ptr_b ? OWN_B : OWN_A;
  assign w_new_owner = w_gnt_b ? OWN_B : OWN_A;
  // The pointer port has used up its burst only if it also owns the current run.
  assign w_limit     = (r_cnt >= c_max_burst) && (r_owner == w_ptr_owner);

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        if (r_ptr_b ^ w_limit) w_gnt_b = 1'b1;
        else                   w_gnt_a = 1'b1;
      end else if (a_req) begin
        w_gnt_a = 1'b1;
      end else if (b_req) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we   = '0;
    ram_addr = r_last_addr;
    ram_din  = r_last_din;
    if (w_gnt_a) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (w_gnt_b) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  assign a_ack      = w_gnt_a;
  assign b_ack      = w_gnt_b;
  // A read in flight when reset arrives must not surface.
  assign a_rd_valid = r_rd_a & ~reset;
  assign b_rd_valid = r_rd_b & ~reset;
  assign a_dout     = a_rd_valid ? ram_dout : r_dout_a;
  assign b_dout     = b_rd_valid ? ram_dout : r_dout_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_ptr_b     <= 1'b0;
      r_cnt       <= 4'd0;
      r_last_addr <= '0;
      r_last_din  <= '0;
      r_rd_a      <= 1'b0;
      r_rd_b      <= 1'b0;
      r_dout_a    <= '0;
      r_dout_b    <= '0;
    end else begin
      if (w_gnt_a || w_gnt_b) begin
        r_last_addr <= ram_addr;
        r_last_din  <= ram_din;
        if (r_owner == w_new_owner) begin
          r_cnt <= (r_cnt >= c_max_burst) ? c_max_burst : r_cnt + 4'd1;
        end else begin
          r_cnt   <= 4'd1;
          r_ptr_b <= w_gnt_b;
        end
        r_owner <= w_new_owner;
      end else begin
        r_cnt   <= 4'd0;
        r_owner <= OWN_NONE;
      end
      r_rd_a <= w_gnt_a && (a_we == c_nb'(0));
      r_rd_b <= w_gnt_b && (b_we == c_nb'(0));
      if (a_rd_valid) r_dout_a <= ram_dout;
      if (b_rd_valid) r_dout_b <= ram_dout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_single_port_ram_arbiter.sv
// ============================================================================
// Module      : tb_single_port_ram_arbiter
// Description : Directed and randomized checks of the two-port RAM arbiter
//               against a grant-history and shadow-memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_single_port_ram_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int NB   = 2;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, b_req;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic [NB-1:0] a_we, b_we;
  logic          a_ack, b_ack, a_rd_valid, b_rd_valid;
  logic [DW-1:0] a_dout, b_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [NB-1:0] ram_we;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  single_port_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_we(a_we),
    .a_ack(a_ack), .a_rd_valid(a_rd_valid), .a_dout(a_dout),
    .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_we(b_we),
    .b_ack(b_ack), .b_rd_valid(b_rd_valid), .b_dout(b_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // RAM: registered read, byte-lane writes
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    for (int i = 0; i < NB; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
  end

  // Reference model state
  logic [DW-1:0] sh [0:(1<<AW)-1];
  int            m_last = 0;   // 0 none, 1 A, 2 B (port of previous grant)
  int            m_run  = 0;   // length of the current run of grants to m_last
  int            m_ptr  = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din  = '0;
  bit            m_pend [2];
  logic [DW-1:0] m_pdata[2];
  logic [DW-1:0] m_hold [2];

  int checks = 0;
  int failures = 0;
  int s_w;
  logic s_arv, s_brv;
  logic [DW-1:0] s_adout, s_bdout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int winner();
    int pref;
    if (reset) return 0;
    if (a_req && b_req) begin
      pref = m_ptr;
      if (m_last == pref && m_run >= MAXB) return 3 - pref;
      return pref;
    end
    if (a_req) return 1;
    if (b_req) return 2;
    return 0;
  endfunction

  task automatic set_a(input bit r, input int ad, input logic [DW-1:0] d, input logic [NB-1:0] we);
    a_req = r; a_addr = AW'(ad); a_din = d; a_we = we;
  endtask

  task automatic set_b(input bit r, input int ad, input logic [DW-1:0] d, input logic [NB-1:0] we);
    b_req = r; b_addr = AW'(ad); b_din = d; b_we = we;
  endtask

  // One clock: check combinational outputs, then advance the model at the edge.
  task automatic cyc();
    int w;
    bit rv;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    logic [NB-1:0] we;
    #1;
    w = winner();
    chk("a_ack", a_ack, w == 1);
    chk("b_ack", b_ack, w == 2);
    chk("ram_we", ram_we, (w == 1) ? a_we : (w == 2) ? b_we : 2'b00);
    chk("ram_addr", ram_addr, (w == 1) ? a_addr : (w == 2) ? b_addr : m_addr);
    chk("ram_din", ram_din, (w == 1) ? a_din : (w == 2) ? b_din : m_din);
    for (int p = 0; p < 2; p++) begin
      rv = m_pend[p] && !reset;
      if (rv) m_hold[p] = m_pdata[p];
      chk(p == 0 ? "a_rd_valid" : "b_rd_valid", p == 0 ? a_rd_valid : b_rd_valid, rv);
      chk(p == 0 ? "a_dout" : "b_dout", p == 0 ? a_dout : b_dout, m_hold[p]);
    end
    s_w = w; s_arv = a_rd_valid; s_brv = b_rd_valid; s_adout = a_dout; s_bdout = b_dout;
    ad = (w == 1) ? a_addr : b_addr;
    d  = (w == 1) ? a_din  : b_din;
    we = (w == 1) ? a_we   : b_we;
    @(posedge clk);
    m_pend[0] = 0; m_pend[1] = 0;
    if (reset) begin
      m_last = 0; m_run = 0; m_ptr = 1; m_addr = '0; m_din = '0;
      m_hold[0] = '0; m_hold[1] = '0;
    end else if (w != 0) begin
      if (we == '0) begin
        m_pend[w-1] = 1; m_pdata[w-1] = sh[ad];
      end else begin
        for (int i = 0; i < NB; i++) if (we[i]) sh[ad][8*i +: 8] = d[8*i +: 8];
      end
      m_addr = ad; m_din = d;
      if (w == m_last) m_run++;
      else begin m_run = 1; m_ptr = w; end
      m_last = w;
    end else begin
      m_last = 0; m_run = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp2 [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    bit seen;
    int prev_w;
    for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; sh[i] = '0; end
    m_pend[0] = 0; m_pend[1] = 0; m_hold[0] = '0; m_hold[1] = '0;
    m_pdata[0] = '0; m_pdata[1] = '0;
    reset = 1'b1;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc();
    chk("rst_ram_addr", ram_addr, 0);

    // 1: A writes then reads addr 5
    set_a(1, 5, 16'h1234, 2'b11); cyc(); chk("t1_wr_ack", s_w, 1);
    set_a(1, 5, 16'h0000, 2'b00); cyc(); chk("t1_rd_ack", s_w, 1);
    set_a(0, 0, 0, 0); cyc();
    chk("t1_rv", s_arv, 1); chk("t1_dout", s_adout, 16'h1234);

    // 2: contested burst pattern from pointer A
    reset = 1'b1; cyc(); reset = 1'b0;
    set_a(1, 20, 0, 0); set_b(1, 21, 0, 0);
    for (int i = 0; i < 10; i++) begin cyc(); chk("t2_seq", s_w, exp2[i]); end

    // 3: byte-lane merge
    set_b(0, 0, 0, 0);
    set_a(1, 9, 16'hAAAA, 2'b11); cyc();
    set_a(0, 0, 0, 0); set_b(1, 9, 16'h5533, 2'b10); cyc();
    set_b(1, 9, 0, 2'b00); cyc();
    set_b(0, 0, 0, 0); cyc();
    chk("t3_rv", s_brv, 1); chk("t3_dout", s_bdout, 16'h55AA);

    // 4: same-address conflict with pointer at B
    set_b(1, 0, 0, 0); cyc(); chk("t4_pre", s_w, 2);
    set_a(1, 3, 16'h7777, 2'b11); set_b(1, 3, 0, 0); cyc(); chk("t4_b_first", s_w, 2);
    set_b(0, 0, 0, 0); cyc();
    chk("t4_a_next", s_w, 1); chk("t4_b_rv", s_brv, 1); chk("t4_old", s_bdout, 16'h0000);
    set_a(1, 3, 0, 0); cyc();
    set_a(0, 0, 0, 0); cyc(); chk("t4_new", s_adout, 16'h7777);

    // 5: reset right after an A read ack, with A's burst saturated
    set_a(1, 5, 0, 0); repeat (4) cyc();
    set_a(0, 0, 0, 0); reset = 1'b1; cyc(); chk("t5_rv", s_arv, 0);
    cyc(); reset = 1'b0;
    cyc();
    chk("t5_ram_addr", ram_addr, 0); chk("t5_adout", a_dout, 0); chk("t5_bdout", b_dout, 0);
    set_a(1, 6, 0, 0); set_b(1, 7, 0, 0); cyc(); chk("t5_first", s_w, 1);

    // 6: B alone, then A joins
    set_a(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      set_b(1, $urandom_range(0, 15), 16'($urandom), 2'($urandom));
      cyc(); chk("t6_b", s_w, 2);
    end
    set_a(1, 8, 0, 0);
    cyc(); seen = (s_w == 1);
    if (!seen) begin cyc(); seen = (s_w == 1); end
    chk("t6_a_bounded", seen, 1);

    // Randomized traffic with holds, drops and occasional resets
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    prev_w = 0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      if (!a_req || prev_w == 1)
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 15), 16'($urandom),
              $urandom_range(0, 1) ? 2'b00 : 2'($urandom));
      else if ($urandom_range(0, 15) == 0) a_req = 1'b0;
      if (!b_req || prev_w == 2)
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 15), 16'($urandom),
              $urandom_range(0, 1) ? 2'b00 : 2'($urandom));
      else if ($urandom_range(0, 15) == 0) b_req = 1'b0;
      cyc();
      prev_w = s_w;
    end
    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
